// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and memory (slave).
interface pc_fetch_sequencer_if;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        fetch_ack;

  modport master (output fetch_addr, output fetch_req, input fetch_ack);
  modport slave  (input fetch_addr, input fetch_req, output fetch_ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer, word-addressed (+1 per instruction).
// Define PC_SEQ_RAS_EN to add call_en/ret_en ports and a RAS_DEPTH-entry return-address stack.
//
//  state | meaning
//  IDLE  | one cycle after reset before the first request
//  REQ   | fetch_req high, fetch_addr = pc, waiting for / taking acks
//  HOLD  | instruction acked under stall; waits for stall to drop, then accepts
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_SEQ_RAS_EN
  ,
  parameter int RAS_DEPTH = 4
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        branch_en,
  input  logic [15:0]                 branch_offset,
  input  logic                        jump_en,
  input  logic [25:0]                 jump_target,
`ifdef PC_SEQ_RAS_EN
  input  logic                        call_en,
  input  logic                        ret_en,
`endif
  pc_fetch_sequencer_if.master        fetch,
  output logic                        instr_valid,
  output logic [31:0]                 last_pc,
  output logic [31:0]                 pc_plus1
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic        pend_vld;
  logic [31:0] pend_pc;

  logic        accept;
  logic [31:0] seq_pc;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;

  assign fetch.fetch_addr = pc;
  assign fetch.fetch_req  = req_q;

  assign accept     = ((state == REQ) && fetch.fetch_ack && !stall) ||
                      ((state == HOLD) && !stall);
  assign seq_pc     = pc + 32'd1;
  // Redirect targets are relative to the previously accepted instruction.
  assign branch_tgt = last_pc + 32'd1 + {{16{branch_offset[15]}}, branch_offset};
  assign jump_tgt   = {last_pc[31:26], jump_target};
  assign redir_tgt  = jump_en ? jump_tgt : branch_tgt;

`ifdef PC_SEQ_RAS_EN
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   RAS_FULL = (PW + 1)'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_top;
  logic [PW:0]   ras_cnt;
  logic          ras_empty;
  logic          ras_pop;
  logic          ras_push;
  logic [PW-1:0] push_idx;

  assign ras_empty = (ras_cnt == '0);
  assign ras_pop   = accept && ret_en && !ras_empty;
  assign ras_push  = accept && call_en;
  // Pop-then-push in one accept rewrites the current top in place.
  assign push_idx  = ras_pop ? ras_top : ras_top + PW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else begin
      if (ras_push) begin
        ras_top <= push_idx;
      end else if (ras_pop) begin
        ras_top <= ras_top - PW'(1);
      end
      if (ras_push && !ras_pop && (ras_cnt != RAS_FULL)) begin
        ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop && !ras_push) begin
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && ras_push) begin
      ras_mem[push_idx] <= seq_pc;
    end
  end
`endif

  always_comb begin
    next_pc = seq_pc;
    if (jump_en) begin
      next_pc = jump_tgt;
    end
`ifdef PC_SEQ_RAS_EN
    else if (ret_en) begin
      next_pc = ras_empty ? seq_pc : ras_mem[ras_top];
    end
`endif
    else if (branch_en) begin
      next_pc = branch_tgt;
    end else if (pend_vld) begin
      next_pc = pend_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      last_pc     <= RESET_PC;
      pc_plus1    <= RESET_PC + 32'd1;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      pend_vld    <= 1'b0;
      pend_pc     <= RESET_PC;
    end else begin
      instr_valid <= accept;
      if (accept) begin
        last_pc  <= pc;
        pc_plus1 <= seq_pc;
        pc       <= next_pc;
        pend_vld <= 1'b0;
      end else if (jump_en || branch_en) begin
        pend_vld <= 1'b1;
        pend_pc  <= redir_tgt;
      end
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (fetch.fetch_ack && stall) begin
            state <= HOLD;
            req_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
